// File: rtl/fp_special_pkg.sv
// Shared encodings for the FP special-case pipeline: op codes, operand classes
// and the canonical quiet NaN builder.
package fp_special_pkg;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        CLS_ZERO   = 3'd0,
        CLS_DENORM = 3'd1,
        CLS_NORMAL = 3'd2,
        CLS_INF    = 3'd3,
        CLS_QNAN   = 3'd4,
        CLS_SNAN   = 3'd5
    } op_class_e;

    localparam int unsigned MAX_WIDTH = 64;

    // Sign 0, exponent all-ones, mantissa MSB set; callers truncate to their width.
    function automatic logic [MAX_WIDTH-1:0] canonical_qnan(input int unsigned exp_width,
                                                            input int unsigned mant_width);
        logic [MAX_WIDTH-1:0] q;
        q = ((MAX_WIDTH'(1) << exp_width) - MAX_WIDTH'(1)) << mant_width;
        q = q | (MAX_WIDTH'(1) << (mant_width - 1));
        return q;
    endfunction

endpackage

// File: rtl/fp_special_case_pipe_if.sv
// Beat-level handshake and flag signals between the FP special-case pipe and its user.
interface fp_special_case_pipe_if #(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned MANT_WIDTH = 23
);
    localparam int unsigned W = EXP_WIDTH + MANT_WIDTH + 1;

    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic         out_special;
    logic [W-1:0] out_result;
    logic         out_invalid;
    logic         out_div_zero;
    logic         flags_clr;
    logic         sticky_invalid;
    logic         sticky_div_zero;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready, flags_clr,
        input  in_ready, out_valid, out_special, out_result, out_invalid, out_div_zero,
               sticky_invalid, sticky_div_zero
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready, flags_clr,
        output in_ready, out_valid, out_special, out_result, out_invalid, out_div_zero,
               sticky_invalid, sticky_div_zero
    );

endinterface

// File: rtl/fp_operand_classifier.sv
// Classifies the exponent/mantissa of one operand; the sign is handled by the caller.
module fp_operand_classifier
    import fp_special_pkg::*;
#(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned MANT_WIDTH = 23,
    parameter bit          FTZ        = 1'b0
) (
    input  logic [EXP_WIDTH+MANT_WIDTH-1:0] magnitude,
    output op_class_e                       cls
);
    logic [EXP_WIDTH-1:0]  exp_f;
    logic [MANT_WIDTH-1:0] mant_f;

    assign {exp_f, mant_f} = magnitude;

    always_comb begin
        cls = CLS_NORMAL;
        if (&exp_f) begin
            if (mant_f == '0) begin
                cls = CLS_INF;
            end else if (mant_f[MANT_WIDTH-1]) begin
                cls = CLS_QNAN;
            end else begin
                cls = CLS_SNAN;
            end
        end else if (exp_f == '0) begin
            // Flushed denormals behave as zero but keep their sign bit.
            if (mant_f == '0 || FTZ) begin
                cls = CLS_ZERO;
            end else begin
                cls = CLS_DENORM;
            end
        end
    end

endmodule

// File: rtl/fp_special_case_pipe.sv
// Two-stage special-case detector for MUL/ADD/SUB/DIV: S1 classifies, S2 holds the
// selected result and flags; sticky flags accumulate on output handshakes.
module fp_special_case_pipe
    import fp_special_pkg::*;
#(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned MANT_WIDTH = 23,
    parameter bit          FTZ        = 1'b0
) (
    input logic                   clk,
    input logic                   rst_n,
    fp_special_case_pipe_if.slave bus
);
    localparam int unsigned W = EXP_WIDTH + MANT_WIDTH + 1;
    localparam logic [W-1:0] QNAN = W'(canonical_qnan(EXP_WIDTH, MANT_WIDTH));

    function automatic logic [W-1:0] inf_val(input logic s);
        return {s, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    endfunction

    function automatic logic [W-1:0] zero_val(input logic s);
        return {s, {(W-1){1'b0}}};
    endfunction

    op_class_e    cls_a, cls_b;
    logic         s1_valid;
    logic [1:0]   s1_op;
    op_class_e    s1_cls_a, s1_cls_b;
    logic [W-1:0] s1_a, s1_b;
    logic         s2_valid, s2_special, s2_invalid, s2_div_zero;
    logic [W-1:0] s2_result;
    logic         sticky_invalid_q, sticky_div_zero_q;

    logic         s2_ready, s1_move, in_fire, out_fire;
    logic         sel_special, sel_invalid, sel_div_zero;
    logic [W-1:0] sel_result;
    logic         a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic         sa, eff_sb, sign_x;

    fp_operand_classifier #(
        .EXP_WIDTH (EXP_WIDTH),
        .MANT_WIDTH(MANT_WIDTH),
        .FTZ       (FTZ)
    ) u_class_a (
        .magnitude(bus.in_a[W-2:0]),
        .cls      (cls_a)
    );

    fp_operand_classifier #(
        .EXP_WIDTH (EXP_WIDTH),
        .MANT_WIDTH(MANT_WIDTH),
        .FTZ       (FTZ)
    ) u_class_b (
        .magnitude(bus.in_b[W-2:0]),
        .cls      (cls_b)
    );

    assign out_fire     = s2_valid && bus.out_ready;
    assign s2_ready     = !s2_valid || bus.out_ready;
    assign s1_move      = s1_valid && s2_ready;
    assign bus.in_ready = !s1_valid || s2_ready;
    assign in_fire      = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_MUL;
            s1_cls_a <= CLS_ZERO;
            s1_cls_b <= CLS_ZERO;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            if (bus.in_ready) s1_valid <= bus.in_valid;
            if (in_fire) begin
                s1_op    <= bus.in_op;
                s1_cls_a <= cls_a;
                s1_cls_b <= cls_b;
                s1_a     <= bus.in_a;
                s1_b     <= bus.in_b;
            end
        end
    end

    assign a_snan = s1_cls_a == CLS_SNAN;
    assign b_snan = s1_cls_b == CLS_SNAN;
    assign a_nan  = a_snan || s1_cls_a == CLS_QNAN;
    assign b_nan  = b_snan || s1_cls_b == CLS_QNAN;
    assign a_inf  = s1_cls_a == CLS_INF;
    assign b_inf  = s1_cls_b == CLS_INF;
    assign a_zero = s1_cls_a == CLS_ZERO;
    assign b_zero = s1_cls_b == CLS_ZERO;
    assign sa     = s1_a[W-1];
    assign sign_x = s1_a[W-1] ^ s1_b[W-1];
    assign eff_sb = s1_b[W-1] ^ (s1_op == OP_SUB);

    always_comb begin
        sel_special  = 1'b1;
        sel_result   = '0;
        sel_invalid  = 1'b0;
        sel_div_zero = 1'b0;
        if (a_nan || b_nan) begin
            sel_result  = QNAN;
            sel_invalid = a_snan || b_snan;
        end else begin
            case (s1_op)
                OP_MUL: begin
                    if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                        sel_result  = QNAN;
                        sel_invalid = 1'b1;
                    end else if (a_inf || b_inf) begin
                        sel_result = inf_val(sign_x);
                    end else if (a_zero || b_zero) begin
                        sel_result = zero_val(sign_x);
                    end else begin
                        sel_special = 1'b0;
                    end
                end
                OP_ADD, OP_SUB: begin
                    if (a_inf && b_inf && (sa != eff_sb)) begin
                        sel_result  = QNAN;
                        sel_invalid = 1'b1;
                    end else if (a_inf) begin
                        sel_result = inf_val(sa);
                    end else if (b_inf) begin
                        sel_result = inf_val(eff_sb);
                    end else if (a_zero && b_zero) begin
                        sel_result = zero_val(sa & eff_sb);
                    end else if (a_zero) begin
                        sel_result = {eff_sb, s1_b[W-2:0]};
                    end else if (b_zero) begin
                        sel_result = s1_a;
                    end else begin
                        sel_special = 1'b0;
                    end
                end
                default: begin
                    if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                        sel_result  = QNAN;
                        sel_invalid = 1'b1;
                    end else if (b_zero && !a_inf) begin
                        sel_result   = inf_val(sign_x);
                        sel_div_zero = 1'b1;
                    end else if (a_inf) begin
                        sel_result = inf_val(sign_x);
                    end else if (a_zero || b_inf) begin
                        sel_result = zero_val(sign_x);
                    end else begin
                        sel_special = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid          <= 1'b0;
            s2_special        <= 1'b0;
            s2_result         <= '0;
            s2_invalid        <= 1'b0;
            s2_div_zero       <= 1'b0;
            sticky_invalid_q  <= 1'b0;
            sticky_div_zero_q <= 1'b0;
        end else begin
            if (s2_ready) s2_valid <= s1_valid;
            if (s1_move) begin
                s2_special  <= sel_special;
                s2_result   <= sel_result;
                s2_invalid  <= sel_invalid;
                s2_div_zero <= sel_div_zero;
            end
            // A handshake that sets a flag wins over a same-cycle clear.
            sticky_invalid_q  <= (sticky_invalid_q && !bus.flags_clr) || (out_fire && s2_invalid);
            sticky_div_zero_q <= (sticky_div_zero_q && !bus.flags_clr) ||
                                 (out_fire && s2_div_zero);
        end
    end

    assign bus.out_valid       = s2_valid;
    assign bus.out_special     = s2_special;
    assign bus.out_result      = s2_result;
    assign bus.out_invalid     = s2_invalid;
    assign bus.out_div_zero    = s2_div_zero;
    assign bus.sticky_invalid  = sticky_invalid_q;
    assign bus.sticky_div_zero = sticky_div_zero_q;

endmodule

// File: tb/tb_fp_special_case_pipe.sv
// Scoreboard bench: an FTZ=0 and an FTZ=1 instance share stimulus; each has its own
// expected-response queue popped by a monitor on output handshakes.
module tb_fp_special_case_pipe;

    typedef struct packed {
        logic        sp;
        logic        inv;
        logic        dz;
        logic [31:0] res;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e0;
        exp_t        e1;
    } vec_t;

    localparam logic [1:0] MUL = 2'd0, ADD = 2'd1, SUB = 2'd2, DIV = 2'd3;
    localparam logic [31:0] QN = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_op = 2'd0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_ready = 1'b1;
    logic        flags_clr = 1'b0;
    logic        ready_toggle = 1'b0;
    logic        ready_hold = 1'b1;
    logic [3:0]  ready_pat = 4'b1001;
    int          ready_idx = 0;

    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q0[$];
    exp_t q1[$];
    vec_t vecs[$];
    bit   prev_stall[2];
    exp_t prev_obs[2];

    fp_special_case_pipe_if #(.EXP_WIDTH(8), .MANT_WIDTH(23)) bus0 ();
    fp_special_case_pipe_if #(.EXP_WIDTH(8), .MANT_WIDTH(23)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_op     = in_op;
    assign bus0.in_a      = in_a;
    assign bus0.in_b      = in_b;
    assign bus0.out_ready = out_ready;
    assign bus0.flags_clr = flags_clr;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_op     = in_op;
    assign bus1.in_a      = in_a;
    assign bus1.in_b      = in_b;
    assign bus1.out_ready = out_ready;
    assign bus1.flags_clr = flags_clr;

    fp_special_case_pipe #(.EXP_WIDTH(8), .MANT_WIDTH(23), .FTZ(1'b0)) dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0.slave)
    );

    fp_special_case_pipe #(.EXP_WIDTH(8), .MANT_WIDTH(23), .FTZ(1'b1)) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (ready_toggle) begin
            out_ready = ready_pat[3 - ready_idx];
            ready_idx = (ready_idx + 1) % 4;
        end else begin
            out_ready = ready_hold;
            ready_idx = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic exp_t mk(input logic sp, input logic inv, input logic dz,
                                input logic [31:0] res);
        exp_t e;
        e.sp  = sp;
        e.inv = inv;
        e.dz  = dz;
        e.res = res;
        return e;
    endfunction

    task automatic add(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e0, input exp_t e1);
        vec_t v;
        v.op = op;
        v.a  = a;
        v.b  = b;
        v.e0 = e0;
        v.e1 = e1;
        vecs.push_back(v);
    endtask

    task automatic observe(input int p, input logic v, input exp_t got);
        exp_t e;
        int   depth;
        if (prev_stall[p]) chk($sformatf("hold%0d", p), 64'({v, got}), 64'({1'b1, prev_obs[p]}));
        if (v && out_ready) begin
            depth = (p == 0) ? q0.size() : q1.size();
            if (depth == 0) begin
                chk($sformatf("spurious_out%0d", p), 64'(depth), 64'd1);
            end else begin
                e = (p == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("result%0d", p), 64'(got), 64'(e));
            end
        end
        prev_stall[p] = v && !out_ready;
        prev_obs[p]   = got;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall[0] = 1'b0;
            prev_stall[1] = 1'b0;
        end else begin
            observe(0, bus0.out_valid, mk(bus0.out_special, bus0.out_invalid,
                                          bus0.out_div_zero, bus0.out_result));
            observe(1, bus1.out_valid, mk(bus1.out_special, bus1.out_invalid,
                                          bus1.out_div_zero, bus1.out_result));
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Must be called 1 time unit after a rising edge.
    task automatic send(input vec_t v);
        bit acc = 1'b0;
        in_op    = v.op;
        in_a     = v.a;
        in_b     = v.b;
        in_valid = 1'b1;
        for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clk);
            acc = bus0.in_ready;
            @(posedge clk);
            #1;
        end
        chk("accept", 64'(acc), 64'd1);
        if (acc) begin
            q0.push_back(v.e0);
            q1.push_back(v.e1);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && (q0.size() != 0 || q1.size() != 0); c++) @(negedge clk);
        chk("drain0", 64'(q0.size()), 64'd0);
        chk("drain1", 64'(q1.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_out_valid0"}, 64'(bus0.out_valid), 64'd0);
        chk({tag, "_out_valid1"}, 64'(bus1.out_valid), 64'd0);
        chk({tag, "_special"}, 64'(bus0.out_special), 64'd0);
        chk({tag, "_result"}, 64'(bus0.out_result), 64'd0);
        chk({tag, "_invalid"}, 64'(bus0.out_invalid), 64'd0);
        chk({tag, "_div_zero"}, 64'(bus0.out_div_zero), 64'd0);
        chk({tag, "_sticky_inv"}, 64'(bus0.sticky_invalid), 64'd0);
        chk({tag, "_sticky_dz"}, 64'(bus0.sticky_div_zero), 64'd0);
        chk({tag, "_in_ready"}, 64'(bus0.in_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t none;
        bit   seen;
        none = mk(1'b0, 1'b0, 1'b0, 32'h0);
        add(MUL, 32'h7F800000, 32'h00000000, mk(1, 1, 0, QN), mk(1, 1, 0, QN));
        add(DIV, 32'hBF800000, 32'h00000000, mk(1, 0, 1, 32'hFF800000), mk(1, 0, 1, 32'hFF800000));
        add(SUB, 32'h7F800000, 32'h7F800000, mk(1, 1, 0, QN), mk(1, 1, 0, QN));
        add(ADD, 32'h7F800000, 32'h7F800000, mk(1, 0, 0, 32'h7F800000), mk(1, 0, 0, 32'h7F800000));
        add(ADD, 32'h7F800001, 32'h3F800000, mk(1, 1, 0, QN), mk(1, 1, 0, QN));
        add(ADD, 32'h7FC00001, 32'h3F800000, mk(1, 0, 0, QN), mk(1, 0, 0, QN));
        add(MUL, 32'h00000001, 32'h3F800000, none, mk(1, 0, 0, 32'h00000000));
        add(ADD, 32'h3F800000, 32'h40000000, none, none);
        add(SUB, 32'h00000000, 32'h3F800000, mk(1, 0, 0, 32'hBF800000), mk(1, 0, 0, 32'hBF800000));
        add(ADD, 32'h80000000, 32'h80000000, mk(1, 0, 0, 32'h80000000), mk(1, 0, 0, 32'h80000000));
        add(SUB, 32'h00000000, 32'h00000000, mk(1, 0, 0, 32'h00000000), mk(1, 0, 0, 32'h00000000));
        add(ADD, 32'h40400000, 32'h80000000, mk(1, 0, 0, 32'h40400000), mk(1, 0, 0, 32'h40400000));
        add(DIV, 32'h00000000, 32'h00000000, mk(1, 1, 0, QN), mk(1, 1, 0, QN));
        add(DIV, 32'hFF800000, 32'h7F800000, mk(1, 1, 0, QN), mk(1, 1, 0, QN));
        add(DIV, 32'h7F800000, 32'hC0000000, mk(1, 0, 0, 32'hFF800000), mk(1, 0, 0, 32'hFF800000));
        add(DIV, 32'h00000000, 32'h40000000, mk(1, 0, 0, 32'h00000000), mk(1, 0, 0, 32'h00000000));
        add(DIV, 32'h3F800000, 32'hFF800000, mk(1, 0, 0, 32'h80000000), mk(1, 0, 0, 32'h80000000));
        add(MUL, 32'hFF800000, 32'h40000000, mk(1, 0, 0, 32'hFF800000), mk(1, 0, 0, 32'hFF800000));
        add(MUL, 32'h80000000, 32'h3F800000, mk(1, 0, 0, 32'h80000000), mk(1, 0, 0, 32'h80000000));
        add(SUB, 32'h3F800000, 32'hFF800000, mk(1, 0, 0, 32'h7F800000), mk(1, 0, 0, 32'h7F800000));
        add(DIV, 32'h3F800000, 32'h00000001, none, mk(1, 0, 1, 32'h7F800000));
        add(MUL, 32'h7F800000, 32'h00000001, mk(1, 0, 0, 32'h7F800000), mk(1, 1, 0, QN));
        add(ADD, 32'h00000001, 32'h3F800000, none, mk(1, 0, 0, 32'h3F800000));
        add(MUL, 32'h7F800001, 32'h00000000, mk(1, 1, 0, QN), mk(1, 1, 0, QN));
        add(ADD, 32'h00000001, 32'h00000000, mk(1, 0, 0, 32'h00000001), mk(1, 0, 0, 32'h00000000));

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");

        // Single inf*0 beat sets the sticky invalid flag once it is consumed
        align();
        send(vecs[0]);
        in_valid = 1'b0;
        drain();
        align();
        chk("sticky_inv_set", 64'(bus0.sticky_invalid), 64'd1);
        chk("sticky_dz_clear", 64'(bus0.sticky_div_zero), 64'd0);
        flags_clr = 1'b1;
        align();
        flags_clr = 1'b0;
        chk("sticky_inv_cleared", 64'(bus0.sticky_invalid), 64'd0);

        // Back-to-back stream with out_ready cycling 1,0,0,1
        ready_toggle = 1'b1;
        align();
        for (int i = 1; i < vecs.size(); i++) send(vecs[i]);
        in_valid = 1'b0;
        drain();
        ready_toggle = 1'b0;
        align();
        align();
        chk("stream_sticky_dz0", 64'(bus0.sticky_div_zero), 64'd1);
        chk("stream_sticky_dz1", 64'(bus1.sticky_div_zero), 64'd1);
        chk("stream_sticky_inv1", 64'(bus1.sticky_invalid), 64'd1);

        flags_clr = 1'b1;
        align();
        flags_clr = 1'b0;
        chk("clr_inv", 64'(bus0.sticky_invalid), 64'd0);
        chk("clr_dz", 64'(bus0.sticky_div_zero), 64'd0);

        // Clear pulsed in the same cycle as an invalid-setting handshake
        send(vecs[2]);
        in_valid = 1'b0;
        for (int c = 0; c < 20 && !bus0.out_valid; c++) @(negedge clk);
        chk("clr_race_valid", 64'(bus0.out_valid), 64'd1);
        flags_clr = 1'b1;
        align();
        flags_clr = 1'b0;
        chk("clr_race_sticky", 64'(bus0.sticky_invalid), 64'd1);
        drain();

        // Reset with beats in flight and downstream stalled
        ready_hold = 1'b0;
        align();
        align();
        in_op    = vecs[1].op;
        in_a     = vecs[1].a;
        in_b     = vecs[1].b;
        in_valid = 1'b1;
        repeat (4) align();
        chk("prefill_valid", 64'(bus0.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1 in_valid = 1'b0;
        check_idle_outputs("midreset");
        align();
        align();
        rst_n      = 1'b1;
        ready_hold = 1'b1;
        seen       = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | bus0.out_valid | bus1.out_valid;
        end
        chk("no_emit_after_reset", 64'(seen), 64'd0);

        // Pipeline still works after the mid-stream reset
        align();
        send(vecs[6]);
        in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_special_case_pipe.md
Name: fp_special_case_pipe

Overview:
- Parametrised, pipelined successor of our operand/operation analysers.
- Classifies two IEEE-754-style operands and decides whether MUL/ADD/SUB/DIV has a special-case result (NaN, infinity, zero, passthrough).
- Produces that result plus per-operation and sticky exception flags.
- Sits in front of the FP datapath; the datapath computes only when out_special=0.

Parameters:
- EXP_WIDTH, 8, exponent field width (>=2).
- MANT_WIDTH, 23, mantissa field width (>=2).
- FTZ, 0, 1: denormal operands are treated as zero, sign kept; 0: denormals are finite non-zero.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- in_op  in  2  0=MUL, 1=ADD, 2=SUB, 3=DIV.
- in_a  in  W  operand A, W=EXP_WIDTH+MANT_WIDTH+1, layout [sign][exp][mant].
- in_b  in  W  operand B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_special  out  1  out_result is final.
- out_result  out  W  special result; all zeros when out_special=0.
- out_invalid  out  1  invalid-operation exception for this beat.
- out_div_zero  out  1  divide-by-zero exception for this beat.
- flags_clr  in  1  synchronous clear of the sticky flags.
- sticky_invalid  out  1  accumulated invalid flag.
- sticky_div_zero  out  1  accumulated div-by-zero flag.

Behaviour:
- Reset (rst_n=0, asynchronous): both stage valids=0, out_valid=0, out_special=0, out_result=0, out_invalid=0, out_div_zero=0, sticky_*=0. in_ready is 1 in the first cycle after reset.
- Pipeline: two stages.
  - S1 registers the operation and the operand classes (zero, denormal, normal, inf, qNaN, sNaN), signs and operands.
  - S2 registers the result and flags.
  - Latency is 2 cycles from input handshake to out_valid with out_ready held high. Throughput is 1 beat/cycle.
- Handshake:
  - A stage loads when its successor is empty or transferring in the same cycle.
  - in_ready = !s1_valid || (s1 moves into S2).
  - out_valid/out_result are stable while out_valid && !out_ready.
  - No beat is dropped or duplicated, and order is preserved.
- Classification:
  - exp all-ones with mant=0 is inf.
  - exp all-ones with mant!=0 is NaN; mant MSB=1 is quiet, MSB=0 is signalling.
  - exp=0 with mant!=0 is denormal; with FTZ=1 it is treated as zero.
- Canonical qNaN: sign 0, exp all-ones, mant MSB 1, rest 0.
- Special-case priority, highest first:
  1. Either operand NaN: result qNaN; invalid=1 iff either operand is sNaN.
  2. MUL:
     - inf*0 or 0*inf: qNaN, invalid.
     - inf*any other value: inf, sign = sa^sb.
     - 0*finite: zero, sign = sa^sb.
  3. ADD/SUB, with effective sign sb' = sb^(op==SUB):
     - inf plus inf of opposite effective sign: qNaN, invalid.
     - Any inf: that inf with its effective sign.
     - 0+0: zero, sign = sa & sb'.
     - 0+x: x with sign sb'.
     - x+0: x unchanged.
  4. DIV:
     - 0/0 or inf/inf: qNaN, invalid.
     - finite non-zero / 0: inf, sign sa^sb, div_zero.
     - inf/finite: inf.
     - 0/non-zero, or finite/inf: zero, sign sa^sb.
  5. Otherwise out_special=0, result 0, flags 0.
- Sticky flags:
  - Updated only on an output handshake (out_valid && out_ready), by OR-ing in out_invalid/out_div_zero.
  - flags_clr clears them. If flags_clr and a setting handshake occur in the same cycle, the flag ends at 1.
  - flags_clr has no effect on in-flight beats.
- Reset mid-operation: all in-flight beats are discarded and nothing is emitted after deassertion.

Decomposition:
- Package fp_special_pkg holds:
  - the op encoding constants (OP_MUL, OP_ADD, OP_SUB, OP_DIV);
  - the 3-bit operand class encoding;
  - a function that builds the canonical qNaN for the given widths.
- One sub-module, fp_operand_classifier (parametrised by EXP_WIDTH, MANT_WIDTH, FTZ), is instantiated twice in S1.
- The result-selection logic stays in the top module.

Test Plan (FP32 defaults):
- MUL a=0x7F800000, b=0x00000000 -> 2 cycles later out_special=1, out_result=0x7FC00000, out_invalid=1; sticky_invalid=1 after the handshake.
- DIV a=0xBF800000, b=0x00000000 -> out_result=0xFF800000, out_div_zero=1, out_invalid=0.
- SUB a=0x7F800000, b=0x7F800000 -> 0x7FC00000 with invalid. ADD of the same operands -> 0x7F800000, no flags.
- ADD a=0x7F800001 (sNaN), b=0x3F800000 -> 0x7FC00000, invalid=1. Repeat with a=0x7FC00001 (qNaN) -> invalid=0.
- MUL a=0x00000001, b=0x3F800000: FTZ=0 gives out_special=0; FTZ=1 gives out_result=0x00000000, out_special=1.
- Stream 8 back-to-back beats with out_ready toggling 1,0,0,1…: no loss, order kept, out_result held while stalled. flags_clr pulsed during a setting handshake -> sticky stays 1. rst_n pulsed low mid-stream -> all outputs return to 0 immediately.
